// File: rtl/sa_row_drain.sv
// rtl/sa_row_drain.sv - systolic array output drain: snapshot PE results, stream rows over valid/ready
// Mode 0 sends lanes {1,0} once per row; mode 1 sends {1,0} then {3,2} per row.
module sa_row_drain #(
  parameter int ROW_NUM = 16,
  parameter int COL_NUM = 16,
  parameter int LANE_W  = 16,
  parameter int ROW_W   = $clog2(ROW_NUM + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               mode,
  input  logic [ROW_W-1:0]                   cfg_rows,
  input  logic                               load,
  output logic                               load_ready,
  input  logic [ROW_NUM*COL_NUM*4*LANE_W-1:0] pe_in,
  output logic [2*LANE_W*COL_NUM-1:0]        out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ROW_W-1:0]                   out_row,
  output logic                               out_half,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done,
  output logic                               err_overrun
);

  localparam int PE_W     = 4 * LANE_W;
  localparam int ROW_BITS = COL_NUM * PE_W;

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t             r_state;
  logic               r_mode;
  logic [ROW_W-1:0]   r_last_row;
  logic [ROW_W-1:0]   r_row_ptr;
  logic               r_half;
  logic               r_done;
  logic               r_err;
  logic [ROW_BITS-1:0] r_snap [ROW_NUM];

  logic               w_accept;
  logic               w_xfer;
  logic               w_last;
  logic [ROW_W-1:0]   w_n;
  logic [ROW_BITS-1:0] w_row_word;

  assign w_accept = load && (r_state == S_IDLE);
  assign w_xfer   = out_valid && out_ready;
  assign w_last   = (r_row_ptr == r_last_row) && (!r_mode || r_half);

  // Out-of-range row counts (0 or above ROW_NUM) mean a full tile.
  assign w_n = (cfg_rows == '0 || cfg_rows > ROW_W'(ROW_NUM)) ? ROW_W'(ROW_NUM) : cfg_rows;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int r = 0; r < ROW_NUM; r++) begin
        r_snap[r] <= pe_in[r*ROW_BITS +: ROW_BITS];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mode     <= 1'b0;
      r_last_row <= '0;
      r_row_ptr  <= '0;
      r_half     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load && r_state != S_IDLE) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_mode     <= mode;
            r_last_row <= w_n - ROW_W'(1);
            r_row_ptr  <= '0;
            r_half     <= 1'b0;
            r_state    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_xfer) begin
            if (w_last) begin
              r_state   <= S_IDLE;
              r_done    <= 1'b1;
              r_row_ptr <= '0;
              r_half    <= 1'b0;
            end else if (!r_mode || r_half) begin
              r_row_ptr <= r_row_ptr + ROW_W'(1);
              r_half    <= 1'b0;
            end else begin
              r_half <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Row select written as a compare chain so the pointer width never has to match the array depth.
  always_comb begin
    w_row_word = '0;
    for (int r = 0; r < ROW_NUM; r++) begin
      if (r_row_ptr == ROW_W'(r)) begin
        w_row_word = r_snap[r];
      end
    end
  end

  for (genvar c = 0; c < COL_NUM; c++) begin : g_col
    logic [PE_W-1:0] w_word;
    assign w_word = w_row_word[c*PE_W +: PE_W];
    assign out_data[c*2*LANE_W +: 2*LANE_W] = !out_valid ? '0 :
                                              r_half ? w_word[PE_W-1 -: 2*LANE_W] :
                                                       w_word[2*LANE_W-1:0];
  end

  assign out_valid   = (r_state == S_DRAIN);
  assign busy        = (r_state == S_DRAIN);
  assign load_ready  = (r_state == S_IDLE);
  assign out_row     = out_valid ? r_row_ptr : '0;
  assign out_half    = out_valid & r_half;
  assign out_last    = out_valid & w_last;
  assign done        = r_done;
  assign err_overrun = r_err;

endmodule

// File: tb/tb_sa_row_drain.sv
// tb/tb_sa_row_drain.sv - directed bench for sa_row_drain
// Lane value pattern: base + r*256 + c*4 + k.
module tb_sa_row_drain;

  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int LW   = 16;
  localparam int RW   = 5;
  localparam int DW   = 2*LW*COLS;
  localparam int PW   = ROWS*COLS*4*LW;

  logic          clk = 1'b0;
  logic          reset;
  logic          mode;
  logic [RW-1:0] cfg_rows;
  logic          load;
  logic          load_ready;
  logic [PW-1:0] pe_in;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_row;
  logic          out_half;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          err_overrun;

  int checks = 0;
  int errors = 0;

  sa_row_drain #(.ROW_NUM(ROWS), .COL_NUM(COLS), .LANE_W(LW)) dut (
    .clk(clk), .reset(reset), .mode(mode), .cfg_rows(cfg_rows), .load(load),
    .load_ready(load_ready), .pe_in(pe_in), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .out_half(out_half), .out_last(out_last),
    .busy(busy), .done(done), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pat(input int base);
    logic [PW-1:0] p;
    p = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        for (int k = 0; k < 4; k++)
          p[(r*COLS+c)*4*LW + k*LW +: LW] = LW'(base + r*256 + c*4 + k);
    return p;
  endfunction

  function automatic logic [DW-1:0] beat(input int base, input int r, input int h);
    logic [DW-1:0] e;
    for (int c = 0; c < COLS; c++) begin
      e[c*2*LW +: LW]      = LW'(base + r*256 + c*4 + 2*h);
      e[c*2*LW + LW +: LW] = LW'(base + r*256 + c*4 + 2*h + 1);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input int base, input int r, input int h, input bit last);
    chk({tag, "_valid"}, 32'(out_valid), 32'(1));
    chk({tag, "_row"}, 32'(out_row), 32'(r));
    chk({tag, "_half"}, 32'(out_half), 32'(h));
    chk({tag, "_last"}, 32'(out_last), 32'(last));
    chk_data({tag, "_data"}, out_data, beat(base, r, h));
  endtask

  task automatic chk_done_cycle(input string tag);
    chk({tag, "_done"}, 32'(done), 32'(1));
    chk({tag, "_ready"}, 32'(load_ready), 32'(1));
    chk({tag, "_valid"}, 32'(out_valid), 32'(0));
    chk_data({tag, "_data0"}, out_data, '0);
  endtask

  int xfers;
  bit bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    reset = 1'b1; mode = 1'b0; cfg_rows = '0; load = 1'b0; out_ready = 1'b1; pe_in = pat(0);
    step(); step();
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_ready", 32'(load_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err_overrun), 32'(0));
    chk("rst_row", 32'({out_row, out_half, out_last}), 32'(0));
    chk_data("rst_data", out_data, '0);
    reset = 1'b0;
    step();

    // Mode 0 full tile, cfg_rows=0
    load = 1'b1;
    step();
    load = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      chk_beat("m0", 0, r, 0, r == ROWS-1);
      chk("m0_busy", 32'({busy, load_ready, done}), 32'(3'b100));
      step();
    end
    chk_done_cycle("m0_end");

    // Back-to-back: load in the done cycle, mode 1 with 3 rows
    load = 1'b1; mode = 1'b1; cfg_rows = 5'd3;
    step();
    load = 1'b0; mode = 1'b0; cfg_rows = 5'd1; pe_in = pat(16'h4000);
    for (int i = 0; i < 6; i++) begin
      chk_beat("m1", 0, i/2, i%2, i == 5);
      step();
    end
    chk_done_cycle("m1_end");
    step();
    chk("done_pulse", 32'(done), 32'(0));

    // Backpressure, cfg_rows above ROW_NUM means full tile
    pe_in = pat(16'h1000); mode = 1'b0; cfg_rows = 5'd17; load = 1'b1;
    step();
    load = 1'b0; xfers = 0;
    for (int cyc = 0; cyc < 100 && xfers < ROWS; cyc++) begin
      out_ready = bp_pat[cyc % 4];
      chk_beat("bp", 16'h1000, xfers, 0, xfers == ROWS-1);
      step();
      if (out_ready) xfers++;
    end
    chk("bp_count", 32'(xfers), 32'(ROWS));
    chk_done_cycle("bp_end");
    out_ready = 1'b1;

    // Overrun: extra load on the 5th drain cycle with different data
    pe_in = pat(16'h2000); cfg_rows = 5'd8; load = 1'b1;
    step();
    load = 1'b0;
    for (int r = 0; r < 8; r++) begin
      chk_beat("ov", 16'h2000, r, 0, r == 7);
      chk("ov_err", 32'(err_overrun), 32'(r >= 5));
      if (r == 4) begin
        load = 1'b1; pe_in = pat(16'h4000);
      end else begin
        load = 1'b0;
      end
      step();
    end
    chk_done_cycle("ov_end");
    step();
    chk("ov_sticky", 32'(err_overrun), 32'(1));

    // Async reset after the row-4 transfer
    pe_in = pat(0); cfg_rows = '0; load = 1'b1;
    step();
    load = 1'b0;
    for (int r = 0; r < 5; r++) step();
    chk("ar_row5", 32'(out_row), 32'(5));
    chk("ar_err_pre", 32'(err_overrun), 32'(1));
    reset = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 32'(0));
    chk("ar_ready", 32'(load_ready), 32'(1));
    chk("ar_err", 32'(err_overrun), 32'(0));
    chk("ar_busy", 32'({busy, out_row, out_half, out_last}), 32'(0));
    chk_data("ar_data", out_data, '0);
    step();
    chk("ar_done_a", 32'(done), 32'(0));
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ar_idle", 32'({done, out_valid, load_ready}), 32'(3'b001));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
